// File: rtl/sig_replay.sv
// Record-then-play sample buffer: captures a burst of mic samples into a local
// RAM, then replays them one at a time over a valid/ready handshake.
module sig_replay #(
  parameter int A_WIDTH = 9,
  parameter int D_WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [A_WIDTH-1:0] length,
  input  logic               sample_en,
  input  logic [D_WIDTH-1:0] mic_signal,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [D_WIDTH-1:0] out_signal,
  output logic               busy,
  output logic               done
);

  localparam int DEPTH = 1 << A_WIDTH;
  localparam logic [A_WIDTH-1:0] PTR_ONE = {{(A_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECORD,
    S_FETCH,
    S_OUTPUT,
    S_DONE
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [A_WIDTH-1:0] wr_ptr;
  logic [A_WIDTH-1:0] rd_ptr;
  logic [A_WIDTH-1:0] len_q;
  logic [A_WIDTH-1:0] last_idx;
  logic [D_WIDTH-1:0] mem [DEPTH];
  logic [D_WIDTH-1:0] rd_data_p1;
  logic               load;
  logic               wr_en;
  logic               rd_en;
  logic               rd_adv;

  assign last_idx = len_q - PTR_ONE;

  // abort overrides every other request, including start and the handshake
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    rd_adv  = 1'b0;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start && (length != '0)) begin
            load    = 1'b1;
            state_d = S_RECORD;
          end
        end
        S_RECORD: begin
          if (sample_en) begin
            wr_en = 1'b1;
            if (wr_ptr == last_idx) state_d = S_FETCH;
          end
        end
        S_FETCH: begin
          rd_en   = 1'b1;
          state_d = S_OUTPUT;
        end
        S_OUTPUT: begin
          if (out_ready) begin
            if (rd_ptr == last_idx) begin
              state_d = S_DONE;
            end else begin
              rd_adv  = 1'b1;
              state_d = S_FETCH;
            end
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // read stage: RAM word registered during FETCH, held through OUTPUT
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      len_q      <= '0;
      rd_data_p1 <= '0;
    end else begin
      if (load) begin
        len_q  <= length;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end
      if (wr_en)  wr_ptr     <= wr_ptr + PTR_ONE;
      if (rd_adv) rd_ptr     <= rd_ptr + PTR_ONE;
      if (rd_en)  rd_data_p1 <= mem[rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= mic_signal;
  end

  assign out_signal = rd_data_p1;
  assign out_valid  = (state_q == S_OUTPUT);
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);

endmodule

// File: tb/tb_sig_replay.sv
// Bench for sig_replay: directed bursts plus randomized bursts, each checked
// against a queue model of "first len enabled samples come back in order".
module tb_sig_replay;

  localparam int A_W = 9;
  localparam int D_W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic           abort;
  logic [A_W-1:0] length;
  logic           sample_en;
  logic [D_W-1:0] mic_signal;
  logic           out_valid;
  logic           out_ready;
  logic [D_W-1:0] out_signal;
  logic           busy;
  logic           done;

  int tests = 0;
  int fails = 0;

  // directed recording stimulus; random stimulus is used once these run dry
  bit             dir_en[$];
  logic [D_W-1:0] dir_mic[$];

  sig_replay #(.A_WIDTH(A_W), .D_WIDTH(D_W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .length(length),
    .sample_en(sample_en), .mic_signal(mic_signal), .out_valid(out_valid),
    .out_ready(out_ready), .out_signal(out_signal), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One burst. Observation index cyc counts edges since the start edge;
  // a handshake seen at cyc is taken by edge cyc+1.
  task automatic run_burst(input int len, input int en_pct, input int rdy_pct,
                           input bit inj_start, input int stall2, input bit do_abort);
    logic [D_W-1:0] exp_q[$];
    logic [D_W-1:0] prev_data;
    logic [D_W-1:0] d;
    logic [D_W-1:0] e;
    bit en, rdy, prev_stall, got_done;
    int written, played, cyc, last_wr, first_v, last_hs, stall;
    written = 0; played = 0; cyc = 0; last_wr = -1; first_v = -1;
    last_hs = -1; stall = 0; prev_stall = 0; got_done = 0; prev_data = '0;
    length = len[A_W-1:0]; start = 1'b1; sample_en = 1'b0; out_ready = 1'b0;
    tick();
    start = 1'b0;
    while (!got_done && cyc < len * 20 + 200) begin
      if (written < len) chk("no_early_valid", out_valid, 0);
      if (prev_stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_signal, prev_data);
      end
      if (done) begin
        chk("played_count", played, len);
        chk("queue_empty", exp_q.size(), 0);
        chk("busy_at_done", busy, 1);
        got_done = 1;
        break;
      end
      rdy = ($urandom_range(0, 99) < rdy_pct);
      if (out_valid && played == 1 && stall < stall2) begin
        rdy = 1'b0;
        stall++;
      end
      if (do_abort && out_valid) begin
        abort = 1'b1; out_ready = 1'b1;
        tick();
        chk("abort_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        abort = 1'b0; out_ready = 1'b0;
        tick();
        chk("abort_no_done", done, 0);
        return;
      end
      if (out_valid && first_v < 0) begin
        first_v = cyc;
        chk("first_valid_latency", cyc - last_wr, 1);
      end
      if (out_valid && rdy) begin
        if (exp_q.size() == 0) begin
          chk("extra_sample", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          chk("play_data", out_signal, e);
        end
        if (rdy_pct == 100 && stall2 == 0 && last_hs >= 0) chk("play_spacing", cyc - last_hs, 2);
        last_hs = cyc;
        played++;
      end
      prev_stall = out_valid && !rdy;
      prev_data  = out_signal;
      if (dir_en.size() > 0) begin
        en = dir_en.pop_front();
        d  = dir_mic.pop_front();
      end else begin
        en = ($urandom_range(0, 99) < en_pct);
        d  = D_W'($urandom);
      end
      if (en && written < len) begin
        exp_q.push_back(d);
        written++;
        if (written == len) last_wr = cyc + 1;
      end
      sample_en = en; mic_signal = d; out_ready = rdy;
      start = inj_start && (cyc == 1);
      if (inj_start && cyc == 1) length = 7;
      tick();
      cyc++;
    end
    chk("burst_done_seen", got_done, 1);
    sample_en = 1'b0; out_ready = 1'b0; start = 1'b0;
    tick();
    chk("done_one_cycle", done, 0);
    chk("busy_falls", busy, 0);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; abort = 1'b0; length = '0;
    sample_en = 1'b0; mic_signal = '0; out_ready = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_data", out_signal, 0);
    tick(); tick();
    rst = 1'b1;
    tick();
    chk("idle_busy", busy, 0);

    // three back-to-back samples, always ready
    dir_en = '{1, 1, 1}; dir_mic = '{8'h11, 8'h22, 8'h33};
    run_burst(3, 100, 100, 0, 0, 0);

    // gaps in sample_en: idle-cycle mic values must never be played
    dir_en = '{1, 0, 0, 1}; dir_mic = '{8'hA0, 8'h5C, 8'hC5, 8'hA1};
    run_burst(2, 100, 100, 0, 0, 0);

    // downstream stalls five cycles on the second sample
    run_burst(4, 100, 100, 0, 5, 0);

    // zero-length start is ignored
    length = '0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("len0_busy", busy, 0);
    tick();
    chk("len0_busy_later", busy, 0);

    // start with length 7 during RECORD is ignored
    run_burst(3, 100, 100, 1, 0, 0);

    // abort during OUTPUT together with out_ready, then a one-sample burst
    run_burst(3, 100, 100, 0, 0, 1);
    run_burst(1, 80, 80, 0, 0, 0);

    for (int b = 0; b < 4; b++) run_burst($urandom_range(1, 40), 60, 60, 0, 0, 0);

    // asynchronous reset between edges in the middle of RECORD
    dir_en = '{1, 1}; dir_mic = '{8'h5A, 8'hA5};
    length = 5; start = 1'b1;
    tick();
    start = 1'b0; sample_en = 1'b1; mic_signal = 8'h5A;
    tick();
    mic_signal = 8'hA5;
    tick();
    dir_en.delete(); dir_mic.delete();
    #2 rst = 1'b0;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_done", done, 0);
    chk("async_rst_data", out_signal, 0);
    sample_en = 1'b0;
    tick();
    chk("rst_held_busy", busy, 0);
    rst = 1'b1;
    tick();
    chk("post_rst_idle", busy, 0);

    run_burst(511, 70, 70, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
